// File: rtl/multicycle_control_unit.sv
// Multicycle controller: walks one instruction at a time through IF/ID/EX/MEM/WB
// and drives stage enables, datapath selects and write strobes, all as registered outputs.
module multicycle_control_unit #(
   parameter int FUNC_W      = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        instr_type,
   input  logic [FUNC_W-1:0] func_code,
   input  logic              stop_bit,
   input  logic              flag_zero,
   input  logic              mem_ready,
   input  logic              halt,
   output logic              en_fetch,
   output logic              en_decode,
   output logic              en_execute,
   output logic [1:0]        sig_pc_src,
   output logic              sig_rb_src,
   output logic [1:0]        sig_alu_src,
   output logic [2:0]        sig_alu_op,
   output logic              sig_mem_read,
   output logic              sig_mem_write,
   output logic              sig_rf_write,
   output logic              sig_wb_sel,
   output logic              halted,
   output logic              error,
   output logic [CNT_W-1:0]  retired
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] T_R = 2'b00;
   localparam logic [1:0] T_S = 2'b01;
   localparam logic [1:0] T_I = 2'b10;
   localparam logic [1:0] T_J = 2'b11;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [1:0]        type_q;
   logic [FUNC_W-1:0] func_q;
   logic              stop_q;
   logic [TW-1:0]     wait_cnt;

   logic [1:0]        cur_type;
   logic [FUNC_W-1:0] cur_func;
   logic              cur_stop;
   logic is_and, is_sub, is_cmp, is_sll, is_slr, is_sllv, is_slrv;
   logic is_andi, is_lw, is_sw, is_beq, is_j, is_jal;
   logic [1:0]        alu_src_d;
   logic [2:0]        alu_op_d;
   logic [1:0]        pc_src_d;
   logic              completes;

   // The fields are only latched at the end of ID, so ID itself decodes the live inputs.
   always_comb begin
      cur_type = (state == S_ID) ? instr_type : type_q;
      cur_func = (state == S_ID) ? func_code  : func_q;
      cur_stop = (state == S_ID) ? stop_bit   : stop_q;

      is_and  = (cur_type == T_R) && (cur_func == FUNC_W'(0));
      is_sub  = (cur_type == T_R) && (cur_func == FUNC_W'(2));
      is_cmp  = (cur_type == T_R) && (cur_func == FUNC_W'(3));
      is_sll  = (cur_type == T_S) && (cur_func == FUNC_W'(0));
      is_slr  = (cur_type == T_S) && (cur_func == FUNC_W'(1));
      is_sllv = (cur_type == T_S) && (cur_func == FUNC_W'(2));
      is_slrv = (cur_type == T_S) && (cur_func == FUNC_W'(3));
      is_andi = (cur_type == T_I) && (cur_func == FUNC_W'(0));
      is_lw   = (cur_type == T_I) && (cur_func == FUNC_W'(2));
      is_sw   = (cur_type == T_I) && (cur_func == FUNC_W'(3));
      is_beq  = (cur_type == T_I) && (cur_func == FUNC_W'(4));
      is_j    = (cur_type == T_J) && (cur_func == FUNC_W'(0));
      is_jal  = (cur_type == T_J) && (cur_func == FUNC_W'(1));

      alu_src_d = 2'd0;
      if (is_sll || is_slr) begin
         alu_src_d = 2'd3;
      end else if (cur_type == T_I) begin
         alu_src_d = is_andi ? 2'd1 : 2'd2;
      end

      alu_op_d = 3'd1;
      if (is_sll || is_sllv) begin
         alu_op_d = 3'd3;
      end else if (is_slr || is_slrv) begin
         alu_op_d = 3'd4;
      end else if (is_and || is_andi) begin
         alu_op_d = 3'd0;
      end else if (is_sub || is_cmp || is_beq) begin
         alu_op_d = 3'd2;
      end

      // A return marker overrides any jump; a taken branch can only complete from EX.
      pc_src_d = 2'd0;
      if (cur_stop) begin
         pc_src_d = 2'd3;
      end else if (cur_type == T_J) begin
         pc_src_d = 2'd2;
      end else if (is_beq && (state == S_EX) && flag_zero) begin
         pc_src_d = 2'd1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IF:   next_state = halt ? S_HALT : S_ID;
         S_ID:   next_state = is_j ? S_IF : S_EX;
         S_EX: begin
            if (is_lw || is_sw || is_jal) begin
               next_state = S_MEM;
            end else if (is_beq || is_cmp) begin
               next_state = S_IF;
            end else begin
               next_state = S_WB;
            end
         end
         // A late mem_ready on the final allowed cycle still wins over the timeout.
         S_MEM: begin
            if (mem_ready) begin
               next_state = is_lw ? S_WB : S_IF;
            end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
               next_state = S_ERR;
            end
         end
         S_WB:   next_state = S_IF;
         S_HALT: next_state = halt ? S_HALT : S_IF;
         S_ERR:  next_state = S_ERR;
         default: next_state = S_IF;
      endcase
      completes = (next_state == S_IF) &&
                  ((state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB));
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= S_IF;
      end else begin
         state <= next_state;
      end
   end

   // Outputs are loaded from the next state so they line up with the state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         type_q        <= 2'd0;
         func_q        <= '0;
         stop_q        <= 1'b0;
         wait_cnt      <= '0;
         en_fetch      <= 1'b1;
         en_decode     <= 1'b0;
         en_execute    <= 1'b0;
         sig_pc_src    <= 2'd0;
         sig_rb_src    <= 1'b0;
         sig_alu_src   <= 2'd0;
         sig_alu_op    <= 3'd0;
         sig_mem_read  <= 1'b0;
         sig_mem_write <= 1'b0;
         sig_rf_write  <= 1'b0;
         sig_wb_sel    <= 1'b0;
         halted        <= 1'b0;
         error         <= 1'b0;
         retired       <= '0;
      end else begin
         if (state == S_ID) begin
            type_q <= instr_type;
            func_q <= func_code;
            stop_q <= stop_bit;
         end
         wait_cnt <= ((state == S_MEM) && (next_state == S_MEM)) ? wait_cnt + TW'(1) : '0;

         en_fetch   <= (next_state == S_IF);
         en_decode  <= (next_state == S_ID);
         en_execute <= (next_state == S_EX);

         if ((state == S_IF) && (next_state == S_ID)) begin
            sig_rb_src <= (instr_type == T_I);
         end
         if ((state == S_ID) && (next_state == S_EX)) begin
            sig_alu_src <= alu_src_d;
            sig_alu_op  <= alu_op_d;
         end
         if (completes) begin
            sig_pc_src <= pc_src_d;
            retired    <= retired + CNT_W'(1);
         end

         sig_mem_read  <= (next_state == S_MEM) && is_lw;
         sig_mem_write <= (next_state == S_MEM) && is_sw;
         sig_rf_write  <= (next_state == S_WB);
         sig_wb_sel    <= (next_state == S_WB) && is_lw;
         halted        <= (next_state == S_HALT);
         if (next_state == S_ERR) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instructions push expectations,
// a negedge monitor measures each completed instruction and compares.
module tb_multicycle_control_unit;

   logic       clock;
   logic       reset_n;
   logic [1:0] instr_type;
   logic [4:0] func_code;
   logic       stop_bit;
   logic       flag_zero;
   logic       mem_ready;
   logic       halt;
   logic       en_fetch, en_decode, en_execute;
   logic [1:0] sig_pc_src;
   logic       sig_rb_src;
   logic [1:0] sig_alu_src;
   logic [2:0] sig_alu_op;
   logic       sig_mem_read, sig_mem_write, sig_rf_write, sig_wb_sel;
   logic       halted, error;
   logic [3:0] retired;

   multicycle_control_unit #(.FUNC_W(5), .CNT_W(4), .MEM_TIMEOUT(15)) dut (
      .clock(clock), .reset_n(reset_n), .instr_type(instr_type), .func_code(func_code),
      .stop_bit(stop_bit), .flag_zero(flag_zero), .mem_ready(mem_ready), .halt(halt),
      .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
      .sig_pc_src(sig_pc_src), .sig_rb_src(sig_rb_src), .sig_alu_src(sig_alu_src),
      .sig_alu_op(sig_alu_op), .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
      .sig_rf_write(sig_rf_write), .sig_wb_sel(sig_wb_sel), .halted(halted),
      .error(error), .retired(retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0] t;
      logic [4:0] f;
      logic       stop;
      logic       fz;
      int         wt;
      int         cyc;
      logic [1:0] pc;
      logic [3:0] ret;
      int         rd;
      int         wr;
      int         rf;
      int         wb;
      bit         chk_alu;
      logic [2:0] op;
      logic [1:0] src;
      logic       rb;
   } item_t;

   item_t exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    wait_n   = 0;

   function automatic item_t mk(input logic [1:0] t, input logic [4:0] f, input logic s,
                                input logic fz, input int wt, input int cyc,
                                input logic [1:0] pc, input logic [3:0] ret, input int rd,
                                input int wr, input int rf, input int wb, input bit ca,
                                input logic [2:0] op, input logic [1:0] src, input logic rb);
      item_t it;
      it.t = t; it.f = f; it.stop = s; it.fz = fz; it.wt = wt; it.cyc = cyc;
      it.pc = pc; it.ret = ret; it.rd = rd; it.wr = wr; it.rf = rf; it.wb = wb;
      it.chk_alu = ca; it.op = op; it.src = src; it.rb = rb;
      return it;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Memory model: holds mem_ready low for wait_n strobed MEM cycles, idles high otherwise.
   int mem_cnt = 0;
   always @(posedge clock) begin
      #1;
      if (sig_mem_read || sig_mem_write) begin
         mem_ready = (mem_cnt >= wait_n);
         mem_cnt++;
      end else begin
         mem_cnt   = 0;
         mem_ready = 1'b1;
      end
   end

   // Monitor: an IF after a decoded instruction marks a completion.
   item_t      e;
   string      nm;
   bit         in_instr = 0;
   int         cyc = 0, rd_n = 0, wr_n = 0, rf_n = 0, wb_n = 0;
   logic [2:0] op_seen;
   logic [1:0] src_seen;
   logic       rb_seen;
   always @(negedge clock) begin
      if (!reset_n) begin
         in_instr = 0;
         cyc      = 0;
      end else if (en_fetch) begin
         if (in_instr) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected completion: actual=1 required=0");
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check_output({nm, " cycles"}, cyc, e.cyc);
               check_output({nm, " pc_src"}, sig_pc_src, e.pc);
               check_output({nm, " retired"}, retired, e.ret);
               check_output({nm, " mem_read cycles"}, rd_n, e.rd);
               check_output({nm, " mem_write cycles"}, wr_n, e.wr);
               check_output({nm, " rf_write cycles"}, rf_n, e.rf);
               check_output({nm, " wb_sel cycles"}, wb_n, e.wb);
               check_output({nm, " rb_src"}, rb_seen, e.rb);
               if (e.chk_alu) begin
                  check_output({nm, " alu_op"}, op_seen, e.op);
                  check_output({nm, " alu_src"}, src_seen, e.src);
               end
            end
         end
         in_instr = 0;
         cyc = 1; rd_n = 0; wr_n = 0; rf_n = 0; wb_n = 0;
      end else begin
         cyc++;
         if (en_decode) begin
            in_instr = 1;
            rb_seen  = sig_rb_src;
         end
         if (en_execute) begin
            op_seen  = sig_alu_op;
            src_seen = sig_alu_src;
         end
         rd_n += int'(sig_mem_read);
         wr_n += int'(sig_mem_write);
         rf_n += int'(sig_rf_write);
         wb_n += int'(sig_wb_sel);
      end
   end

   // Presents one instruction in its IF cycle and returns once the block has left IF.
   task automatic apply_stimulus(input string name, input item_t it, input bit push);
      int n;
      n = 0;
      while (en_fetch !== 1'b1 && n < 60) begin step(); n++; end
      check_output({name, " fetch reached"}, en_fetch, 1);
      instr_type = it.t;
      func_code  = it.f;
      stop_bit   = it.stop;
      flag_zero  = it.fz;
      wait_n     = it.wt;
      if (push) begin
         exp_q.push_back(it);
         name_q.push_back(name);
      end
      n = 0;
      while (en_fetch === 1'b1 && n < 60) begin step(); n++; end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int wcount;
      reset_n = 1'b0; halt = 1'b0; instr_type = 2'd0; func_code = 5'd0;
      stop_bit = 1'b0; flag_zero = 1'b0; mem_ready = 1'b1;
      repeat (2) step();
      check_output("reset en_fetch", en_fetch, 1);
      check_output("reset enables", {en_decode, en_execute}, 0);
      check_output("reset selects", {sig_pc_src, sig_rb_src, sig_alu_src, sig_alu_op}, 0);
      check_output("reset strobes", {sig_mem_read, sig_mem_write, sig_rf_write, sig_wb_sel}, 0);
      check_output("reset flags", {halted, error}, 0);
      check_output("reset retired", retired, 0);
      reset_n = 1'b1;

      //                 t  f  s fz wt cyc pc ret rd wr rf wb ca op src rb
      apply_stimulus("ADD",   mk(0, 1, 0, 0, 0,  4, 0,  1, 0, 0, 1, 0, 1, 1, 0, 0), 1);
      apply_stimulus("LW",    mk(2, 2, 0, 0, 3,  8, 0,  2, 4, 0, 1, 1, 1, 1, 2, 1), 1);
      apply_stimulus("BEQ1",  mk(2, 4, 0, 1, 0,  3, 1,  3, 0, 0, 0, 0, 1, 2, 2, 1), 1);
      apply_stimulus("BEQ0",  mk(2, 4, 0, 0, 0,  3, 0,  4, 0, 0, 0, 0, 1, 2, 2, 1), 1);
      apply_stimulus("JALRET",mk(3, 1, 1, 0, 0,  4, 3,  5, 0, 0, 0, 0, 0, 0, 0, 0), 1);
      apply_stimulus("J",     mk(3, 0, 0, 0, 0,  2, 2,  6, 0, 0, 0, 0, 0, 0, 0, 0), 1);
      apply_stimulus("SUB",   mk(0, 2, 0, 0, 0,  4, 0,  7, 0, 0, 1, 0, 1, 2, 0, 0), 1);
      apply_stimulus("SLL",   mk(1, 0, 0, 0, 0,  4, 0,  8, 0, 0, 1, 0, 1, 3, 3, 0), 1);
      apply_stimulus("SLRV",  mk(1, 3, 0, 0, 0,  4, 0,  9, 0, 0, 1, 0, 1, 4, 0, 0), 1);
      apply_stimulus("ANDI",  mk(2, 0, 0, 0, 0,  4, 0, 10, 0, 0, 1, 0, 1, 0, 1, 1), 1);
      apply_stimulus("CMP",   mk(0, 3, 0, 0, 0,  3, 0, 11, 0, 0, 0, 0, 1, 2, 0, 0), 1);
      apply_stimulus("SW",    mk(2, 3, 0, 0, 0,  4, 0, 12, 0, 1, 0, 0, 1, 1, 2, 1), 1);
      apply_stimulus("LWEDGE",mk(2, 2, 0, 0, 14, 19, 0, 13, 15, 0, 1, 1, 1, 1, 2, 1), 1);

      apply_stimulus("ADDHALT", mk(0, 1, 0, 0, 0, 4, 0, 14, 0, 0, 1, 0, 1, 1, 0, 0), 1);
      n = 0;
      while (!en_execute && n < 20) begin step(); n++; end
      halt = 1'b1;
      n = 0;
      while (!halted && n < 20) begin step(); n++; end
      check_output("halt entered", halted, 1);
      check_output("halt quiet", {en_fetch, en_decode, en_execute, sig_mem_read,
                                  sig_mem_write, sig_rf_write}, 0);
      repeat (3) step();
      check_output("halt held", {halted, en_fetch}, 2'b10);
      halt = 1'b0;
      step();
      check_output("resume fetch", {en_fetch, halted}, 2'b10);

      apply_stimulus("UNDEF", mk(0, 7, 0, 0, 0, 4, 0, 15, 0, 0, 1, 0, 1, 1, 0, 0), 1);
      apply_stimulus("JWRAP0",mk(3, 0, 0, 0, 0, 2, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
      apply_stimulus("JWRAP1",mk(3, 0, 0, 0, 0, 2, 2,  1, 0, 0, 0, 0, 0, 0, 0, 0), 1);

      // Reset in the middle of a stalled load.
      apply_stimulus("LWABORT", mk(2, 2, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      n = 0;
      while (!sig_mem_read && n < 20) begin step(); n++; end
      check_output("abort mem_read seen", sig_mem_read, 1);
      repeat (2) step();
      reset_n = 1'b0;
      step();
      check_output("abort strobes", {sig_mem_read, sig_mem_write, sig_rf_write, sig_wb_sel}, 0);
      check_output("abort fetch", en_fetch, 1);
      check_output("abort retired", retired, 0);
      reset_n = 1'b1;

      // Store that never completes must time out after 15 MEM cycles.
      apply_stimulus("SWTIMEOUT", mk(2, 3, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      wcount = 0;
      n = 0;
      while (!error && n < 40) begin
         step();
         n++;
         if (sig_mem_write) wcount++;
      end
      check_output("timeout error", error, 1);
      check_output("timeout mem cycles", wcount, 15);
      check_output("timeout quiet", {sig_mem_read, sig_mem_write, sig_rf_write,
                                     en_fetch, en_decode, en_execute}, 0);
      repeat (5) step();
      check_output("err sticky", {error, en_fetch}, 2'b10);
      reset_n = 1'b0;
      step();
      check_output("err cleared", {error, en_fetch}, 2'b01);
      check_output("err retired", retired, 0);
      reset_n = 1'b1;

      apply_stimulus("ADDPOST", mk(0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0), 1);

      n = 0;
      while (exp_q.size() > 0 && n < 60) begin step(); n++; end
      check_output("queue drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle controller that sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives stage enables, datapath mux selects and memory/register-file write strobes. Compared with the earlier fixed five-stage sequencer it adds:
- a variable-latency data-memory handshake with timeout;
- a halt/resume input;
- instruction-field latching at decode;
- a retired-instruction counter.

It sits between the instruction register and the datapath muxes, ALU, register file and data memory.

## Interface
- FUNC_W, 5, function-code width (≥3)
- CNT_W, 16, retired-counter width
- MEM_TIMEOUT, 15, maximum consecutive MEM cycles without `mem_ready` before error (≥1)
- clock  in  1  sole clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- instr_type  in  2  R=00, S=01, I=10, J=11
- func_code  in  FUNC_W  function code
- stop_bit  in  1  return-from-subroutine marker
- flag_zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completed access
- halt  in  1  request to pause before next fetch
- en_fetch / en_decode / en_execute  out  1 each  one-hot stage enables
- sig_pc_src  out  2  0 next, 1 BTA, 2 JTA, 3 return address
- sig_rb_src  out  1  1 for I-type
- sig_alu_src  out  2  0 Rb, 1 unsigned imm, 2 signed imm, 3 SA imm
- sig_alu_op  out  3  0 AND, 1 ADD, 2 SUB, 3 SLL, 4 SLR
- sig_mem_read / sig_mem_write  out  1  data-memory strobes
- sig_rf_write  out  1  register-file write enable
- sig_wb_sel  out  1  1 memory data, 0 ALU result
- halted  out  1  in HALT state
- error  out  1  sticky memory-timeout flag
- retired  out  CNT_W  completed-instruction count

## Operation
- Function codes:
  - R: AND=0, ADD=1, SUB=2, CMP=3.
  - S: SLL=0, SLR=1, SLLV=2, SLRV=3.
  - I: ANDI=0, ADDI=1, LW=2, SW=3, BEQ=4.
  - J: J=0, JAL=1.
  - Codes are zero-extended to FUNC_W. Undefined codes execute as ADD and go to WB.
- States: IF, ID, EX, MEM, WB, HALT, ERR.
- Field latching: `instr_type`, `func_code` and `stop_bit` are latched on the ID cycle. All later decisions use the latched copies.
- Transitions:
  - IF: to HALT if `halt`=1, else ID.
  - ID: J → IF; all others → EX.
  - EX: LW, SW, JAL → MEM; BEQ, CMP → IF; others → WB.
  - MEM: waits for `mem_ready`. When `mem_ready`=1: LW → WB, else → IF.
  - WB → IF.
  - HALT: → IF when `halt`=0.
  - ERR: terminal until reset.
- Memory timeout: a counter tracks consecutive MEM cycles with `mem_ready`=0. If it reaches MEM_TIMEOUT: go to ERR, set `error`=1, drop all strobes.
- ALU source: S SLL/SLR → 3; other S and all R → 0; ANDI → 1; other I → 2. Set in EX, held until the next EX.
- ALU op: SLL/SLLV → 3; SLR/SLRV → 4; AND/ANDI → 0; SUB/CMP/BEQ → 2; else 1.
- `sig_rb_src` is set in ID from the live `instr_type`.
- PC source: computed on each transition into IF from a completing state, and held until the next such transition. Priority order:
  1. latched stop → 3
  2. J-type → 2
  3. BEQ with `flag_zero`=1 sampled in EX → 1
  4. otherwise → 0
- Strobes:
  - `sig_mem_read` = 1 throughout MEM for LW.
  - `sig_mem_write` = 1 throughout MEM for SW.
  - `sig_rf_write` = 1 only in WB.
  - `sig_wb_sel` = 1 in WB for LW.
- `retired` increments by 1 on every completion edge: ID→IF, EX→IF, MEM→IF and WB→IF. It wraps modulo 2^CNT_W.

## Timing
- All outputs are registered and reflect the current state.
- Reset (`reset_n`=0 at a posedge) gives:
  - state IF, `en_fetch`=1, other enables 0;
  - all selects, strobes, `halted`, `error` = 0;
  - `retired` = 0, timeout counter = 0.
- Reset mid-MEM aborts the access: strobes are 0 on the next cycle.
- Latency with zero memory wait (cycles from IF to the next IF):
  - J: 2
  - BEQ, CMP: 3
  - SW, JAL: 4
  - R/S/ALU-I: 4
  - LW: 5
- Each MEM wait cycle adds 1.
- `mem_ready` arriving on the same cycle the counter would reach MEM_TIMEOUT counts as success; no error is raised.
- `halt` is only sampled in IF. A `halt` pulse mid-instruction is ignored. HALT keeps all enables and strobes at 0.

## Test plan
- ADD (R, 1) with `mem_ready` idle:
  - enables cycle IF→ID→EX→WB→IF;
  - `sig_alu_op`=1, `sig_alu_src`=0;
  - `sig_rf_write`=1 in WB only;
  - `retired` 0→1.
- LW with `mem_ready` low for 3 cycles:
  - `sig_mem_read` high for 4 cycles;
  - WB has `sig_wb_sel`=1;
  - total 8 cycles.
- BEQ with `flag_zero`=1, then with 0: `sig_pc_src`=1, then 0; 3 cycles each; no `sig_rf_write`.
- JAL with `stop_bit`=1: `sig_pc_src`=3 (stop has priority over jump); J completes in 2 cycles with `sig_pc_src`=2.
- SW with `mem_ready` held low, MEM_TIMEOUT=15: after 15 MEM cycles `error`=1 and strobes are 0; the block stays in ERR; `reset_n`=0 clears it back to IF.
- `halt`=1 during EX of ADD: the instruction completes; then `halted`=1 with all enables 0. Releasing `halt` gives `en_fetch`=1 on the next cycle. Separately, run 2^CNT_W+1 instructions with CNT_W=4: `retired` wraps to 1.
